// File: rtl/cart_bs_detect.sv
// Bank-switch detector for the A2601 ROM download path: counts signature opcode
// sequences and measures the image, then publishes mode/size/SuperChip once the download ends.
module cart_bs_detect #(
  parameter int THRESH = 2,
  parameter int SAT    = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [19:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [3:0]  ext_bs,
  input  logic        sc_req,
  output logic [3:0]  force_bs,
  output logic [19:0] cart_size,
  output logic        sc,
  output logic        valid
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DECIDE} state_t;

  localparam logic [7:0] THRESH_V = 8'(THRESH);
  localparam logic [7:0] SAT_V    = 8'(SAT);

  localparam logic [23:0] E0_PATS [8] = '{
    24'h8DE01F, 24'h8DE05F, 24'h8DE9FF, 24'h0CE01F,
    24'hADE01F, 24'hADE9FF, 24'hADEDFF, 24'hADF3BF
  };
  localparam logic [39:0] FE_PATS [4] = '{
    40'h2000D0C6C5, 40'h20C3F8A582, 40'hD0FB2073FE, 40'h2000F084D6
  };

  state_t      r_state, w_state_nxt;
  logic        r_dl_q;
  logic [39:0] r_win;          // [7:0] newest byte, [39:32] oldest
  logic [7:0]  r_fe_hits, r_e0_hits, r_f3_hits;
  logic [19:0] r_max_addr;
  logic        r_any_wr;
  logic [3:0]  r_ext_q;
  logic        r_sc_q;
  logic [3:0]  r_force_bs;
  logic [19:0] r_cart_size;
  logic        r_sc, r_valid;

  logic        w_rise, w_fall, w_start, w_wr;
  logic [39:0] w_win_nxt;
  logic        w_f3_hit, w_e0_hit, w_fe_hit;
  logic [19:0] w_size;
  logic [3:0]  w_bs;

  assign w_rise    = !r_dl_q && ioctl_download;
  assign w_fall    = r_dl_q && !ioctl_download;
  assign w_start   = (r_state == S_IDLE) && w_rise;
  // A strobe coinciding with the falling edge is not part of the image.
  assign w_wr      = (r_state == S_SCAN) && ioctl_wr && ioctl_download;
  assign w_win_nxt = {r_win[31:0], ioctl_dout};

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_rise) w_state_nxt = S_SCAN;
      S_SCAN:   if (w_fall) w_state_nxt = S_DECIDE;
      S_DECIDE: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_f3_hit = (w_win_nxt[15:0] == 16'h853F);
    w_e0_hit = 1'b0;
    w_fe_hit = 1'b0;
    for (int i = 0; i < 8; i++)
      if (w_win_nxt[23:0] == E0_PATS[i]) w_e0_hit = 1'b1;
    for (int i = 0; i < 4; i++)
      if (w_win_nxt == FE_PATS[i]) w_fe_hit = 1'b1;
  end

  always_comb begin
    w_size = '0;
    if (r_any_wr) w_size = (&r_max_addr) ? 20'hFFFFF : r_max_addr + 20'd1;
    w_bs = 4'd0;
    if (r_ext_q != 4'd0)
      w_bs = r_ext_q;
    else if (w_size == 20'd8192 && r_fe_hits != 8'd0)
      w_bs = 4'd3;
    else if (w_size == 20'd8192 && r_e0_hits >= THRESH_V)
      w_bs = 4'd4;
    else if (w_size[10:0] == 11'd0 && w_size >= 20'd4096 && r_f3_hits >= THRESH_V)
      w_bs = 4'd5;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_dl_q      <= 1'b1;   // a line already high at reset must not look like a new download
      r_win       <= '0;
      r_fe_hits   <= '0;
      r_e0_hits   <= '0;
      r_f3_hits   <= '0;
      r_max_addr  <= '0;
      r_any_wr    <= 1'b0;
      r_ext_q     <= '0;
      r_sc_q      <= 1'b0;
      r_force_bs  <= '0;
      r_cart_size <= '0;
      r_sc        <= 1'b0;
      r_valid     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dl_q  <= ioctl_download;

      if (w_start) begin
        r_win      <= '0;
        r_fe_hits  <= '0;
        r_e0_hits  <= '0;
        r_f3_hits  <= '0;
        r_max_addr <= '0;
        r_any_wr   <= 1'b0;
        r_valid    <= 1'b0;
        r_ext_q    <= ext_bs;
        r_sc_q     <= sc_req;
      end

      if (w_wr) begin
        r_win    <= w_win_nxt;
        r_any_wr <= 1'b1;
        if (ioctl_addr > r_max_addr) r_max_addr <= ioctl_addr;
        if (w_f3_hit && r_f3_hits != SAT_V) r_f3_hits <= r_f3_hits + 8'd1;
        if (w_e0_hit && r_e0_hits != SAT_V) r_e0_hits <= r_e0_hits + 8'd1;
        if (w_fe_hit && r_fe_hits != SAT_V) r_fe_hits <= r_fe_hits + 8'd1;
      end

      if (r_state == S_DECIDE) begin
        r_force_bs  <= w_bs;
        r_cart_size <= w_size;
        r_sc        <= r_sc_q;
        r_valid     <= 1'b1;
      end
    end
  end

  assign force_bs  = r_force_bs;
  assign cart_size = r_cart_size;
  assign sc        = r_sc;
  assign valid     = r_valid;

endmodule
